// File: rtl/norm_pkg.sv
// Shared constants for the CLZ/CLO normalizer: FSM encodings, op codes, default sizes.
package norm_pkg;
  localparam int WIDTH_DEFAULT = 32;
  localparam int CNT_W_DEFAULT = 6;
  localparam int STEP_W        = 3;

  localparam logic [STEP_W-1:0] STEP_INIT = 3'd4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic OP_CLZ = 1'b0;
  localparam logic OP_CLO = 1'b1;
endpackage

// File: rtl/norm_counter_if.sv
// Request/response handshake bundle for norm_counter; master = requester, slave = the unit.
interface norm_counter_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_op;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_count;
  logic [WIDTH-1:0] out_norm;
  logic             out_zero;

  modport master (
    output in_valid, in_data, in_op, out_ready,
    input  in_ready, out_valid, out_count, out_norm, out_zero
  );
  modport slave (
    input  in_valid, in_data, in_op, out_ready,
    output in_ready, out_valid, out_count, out_norm, out_zero
  );
endinterface

// File: rtl/norm_counter_step.sv
// One binary-search stage: tests the top 2^step bits against the pad bit and shifts them out on a hit.
module norm_step
  import norm_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic [WIDTH-1:0]  work,
  input  logic [STEP_W-1:0] step,
  input  logic              p,
  output logic              hit,
  output logic [WIDTH-1:0]  shifted,
  output logic [CNT_W-1:0]  inc
);
  logic [CNT_W-1:0] w;
  logic [WIDTH-1:0] mask;

  always_comb begin
    w       = CNT_W'(1) << step;
    // ones in the top w bits
    mask    = ~({WIDTH{1'b1}} >> w);
    hit     = ((work ^ {WIDTH{p}}) & mask) == '0;
    shifted = work << w;
    inc     = hit ? w : '0;
  end
endmodule

// File: rtl/norm_counter.sv
// Iterative CLZ/CLO counter and left-normalizer (one search stage per cycle).
// Optional macro NORM_EARLY_EXIT_EN: leave SCAN as soon as the MSB differs from the pad bit.
module norm_counter
  import norm_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input logic           clk,
  input logic           rst_n,
  norm_counter_if.slave bus
);
  logic [1:0]        state_q, state_d;
  logic [WIDTH-1:0]  work_q,  work_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [STEP_W-1:0] step_q,  step_d;
  logic              p_q,     p_d;
  logic              zero_q,  zero_d;

  logic              hit;
  logic [WIDTH-1:0]  shifted;
  logic [CNT_W-1:0]  inc;

  norm_step #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_step (
    .work    (work_q),
    .step    (step_q),
    .p       (p_q),
    .hit     (hit),
    .shifted (shifted),
    .inc     (inc)
  );

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.out_count = cnt_q;
  assign bus.out_norm  = work_q;
  assign bus.out_zero  = zero_q;

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    p_d     = p_q;
    zero_d  = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          work_d = bus.in_data;
          p_d    = bus.in_op;
          cnt_d  = '0;
          step_d = STEP_INIT;
          zero_d = 1'b0;
          // all-pad operand would need WIDTH shifts; resolve it on the accept edge
          if (bus.in_data == {WIDTH{bus.in_op}}) begin
            cnt_d   = CNT_W'(WIDTH);
            work_d  = '0;
            zero_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_SCAN;
          end
        end
      end
      ST_SCAN: begin
`ifdef NORM_EARLY_EXIT_EN
        if (work_q[WIDTH-1] != p_q) state_d = ST_DONE;
        else
`endif
        begin
          if (hit) begin
            work_d = shifted;
            cnt_d  = cnt_q + inc;
          end
          if (step_q == '0) state_d = ST_DONE;
          else              step_d  = step_q - 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      step_q  <= '0;
      p_q     <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      p_q     <= p_d;
      zero_q  <= zero_d;
    end
  end
endmodule

// File: tb/tb_norm_counter.sv
// Directed bench for norm_counter: hand-computed counts, normalized data and latencies.
module tb_norm_counter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  norm_counter_if #(.WIDTH(32), .CNT_W(6)) bus ();
  norm_counter #(.WIDTH(32), .CNT_W(6)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // issue one request, measure edges to out_valid (accept edge = 1), check result
  task automatic run(input string tag, input logic [31:0] data, input logic op,
                     input logic [5:0] e_cnt, input logic [31:0] e_norm, input logic e_zero,
                     input int lat_fixed, input int lat_early);
    int lat;
    int e_lat;
`ifdef NORM_EARLY_EXIT_EN
    e_lat = lat_early;
`else
    e_lat = lat_fixed;
`endif
    chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_op    = op;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = ~data;
    bus.in_op    = ~op;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, e_lat);
    chk({tag, "_count"}, {26'd0, bus.out_count}, {26'd0, e_cnt});
    chk({tag, "_norm"}, bus.out_norm, e_norm);
    chk({tag, "_zero"}, {31'd0, bus.out_zero}, {31'd0, e_zero});
  endtask

  task automatic drain(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, "_drain_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, "_drain_ready"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_op     = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_count", {26'd0, bus.out_count}, 32'd0);
    chk("rst_norm", bus.out_norm, 32'd0);
    chk("rst_zero", {31'd0, bus.out_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run("clz_1", 32'h0000_0001, 1'b0, 6'd31, 32'h8000_0000, 1'b0, 6, 6);
    drain("clz_1");
    run("clz_0", 32'h0000_0000, 1'b0, 6'd32, 32'h0000_0000, 1'b1, 1, 1);
    drain("clz_0");
    run("clo_ffff0f00", 32'hFFFF_0F00, 1'b1, 6'd16, 32'h0F00_0000, 1'b0, 6, 3);
    drain("clo_ffff0f00");
    run("clo_ones", 32'hFFFF_FFFF, 1'b1, 6'd32, 32'h0000_0000, 1'b1, 1, 1);
    drain("clo_ones");
    run("clz_00f01234", 32'h00F0_1234, 1'b0, 6'd8, 32'hF012_3400, 1'b0, 6, 4);
    drain("clz_00f01234");
    run("clo_7fff", 32'h7FFF_FFFF, 1'b1, 6'd0, 32'h7FFF_FFFF, 1'b0, 6, 2);
    drain("clo_7fff");
    run("clz_msb", 32'h8000_0000, 1'b0, 6'd0, 32'h8000_0000, 1'b0, 6, 2);

    // backpressure: results held, no new request accepted
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h0000_00FF;
      bus.in_op    = 1'b0;
      @(posedge clk); #1;
      chk("bp_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("bp_count", {26'd0, bus.out_count}, 32'd0);
      chk("bp_norm", bus.out_norm, 32'h8000_0000);
    end
    bus.in_valid = 1'b0;
    drain("bp");

    // reset during the third SCAN cycle
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h0000_0001;
    bus.in_op    = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_in_ready", {31'd0, bus.in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("mid_rst_count", {26'd0, bus.out_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_valid", {31'd0, bus.out_valid}, 32'd0);

    run("clz_00010000", 32'h0001_0000, 1'b0, 6'd15, 32'h8000_0000, 1'b0, 6, 6);
    drain("clz_00010000");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
